// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the ALU control decoder: ALUOp classes, ALU op codes, funct7 forms.
package alu_ctrl_pkg;

    localparam logic [1:0] ALUOP_R   = 2'b00;
    localparam logic [1:0] ALUOP_I   = 2'b01;
    localparam logic [1:0] ALUOP_MEM = 2'b10;
    localparam logic [1:0] ALUOP_BR  = 2'b11;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_AND  = 4'b0010,
        ALU_OR   = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SLL  = 4'b0101,
        ALU_SRL  = 4'b0110,
        ALU_SRA  = 4'b0111,
        ALU_SLT  = 4'b1000,
        ALU_SLTU = 4'b1001
    } alu_op_e;

    localparam logic [6:0] F7_NORM = 7'h10;
    localparam logic [6:0] F7_ALT  = 7'h30;
    localparam logic [6:0] F7_U    = 7'h01;

    function automatic logic is_known_f7(input logic [6:0] f7);
        return (f7 == F7_NORM) || (f7 == F7_ALT) || (f7 == F7_U);
    endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational decode of ALUOp/funct3/funct7 into an ALU op code and an illegal flag.
// The illegal flag is only computed when ALU_CTRL_ILLEGAL_EN is defined; otherwise it is tied to 0.
module alu_ctrl_decode
    import alu_ctrl_pkg::*;
(
    input  logic [1:0] i_alu_op,
    input  logic [2:0] i_funct3,
    input  logic [6:0] i_funct7,
    output alu_op_e    o_op,
    output logic       o_illegal
);

    always_comb begin
        o_op = ALU_ADD;
        case (i_alu_op)
            ALUOP_R: begin
                // Custom R-type map; alternate forms are selected by single funct7 bits.
                case (i_funct3)
                    3'd0: o_op = ALU_AND;
                    3'd1: o_op = i_funct7[5] ? ALU_SUB : ALU_ADD;
                    3'd2: o_op = ALU_SLL;
                    3'd3: o_op = ALU_ADD;
                    3'd4: o_op = i_funct7[0] ? ALU_SLTU : ALU_SLT;
                    3'd5: o_op = ALU_XOR;
                    3'd6: o_op = i_funct7[5] ? ALU_SRA : ALU_SRL;
                    default: o_op = ALU_OR;
                endcase
            end
            ALUOP_I: begin
                case (i_funct3)
                    3'd0: o_op = ALU_ADD;
                    3'd1: o_op = ALU_SLL;
                    3'd2: o_op = ALU_SLT;
                    3'd3: o_op = ALU_SLTU;
                    3'd4: o_op = ALU_XOR;
                    3'd5: o_op = i_funct7[5] ? ALU_SRA : ALU_SRL;
                    3'd6: o_op = ALU_OR;
                    default: o_op = ALU_AND;
                endcase
            end
            ALUOP_MEM: o_op = ALU_ADD;
            default:   o_op = ALU_SUB;
        endcase
    end

`ifdef ALU_CTRL_ILLEGAL_EN
    logic w_r_illegal;
    assign w_r_illegal = (i_funct3 == 3'd3)
                       || !is_known_f7(i_funct7)
                       || (i_funct7[5] && (i_funct3 != 3'd1) && (i_funct3 != 3'd6));
    assign o_illegal = (i_alu_op == ALUOP_R) && w_r_illegal;
`else
    logic w_unused_f7;
    assign w_unused_f7 = ^{i_funct7[6], i_funct7[4:1]};
    assign o_illegal   = 1'b0;
`endif

endmodule

// File: rtl/alu_control.sv
// ALU control: registered decode of ALUOp/funct fields with a one-cycle valid pipe.
// illegal is live only when ALU_CTRL_ILLEGAL_EN is defined; otherwise it stays 0.
module alu_control
    import alu_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [1:0] ALUOp,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output logic [3:0] alu_ctrl,
    output logic       out_valid,
    output logic       illegal
);

    alu_op_e w_op;
    logic    w_illegal;

    alu_ctrl_decode u_decode (
        .i_alu_op  (ALUOp),
        .i_funct3  (funct3),
        .i_funct7  (funct7),
        .o_op      (w_op),
        .o_illegal (w_illegal)
    );

    logic [3:0] r_alu_ctrl;
    logic       r_out_valid;
    logic       r_illegal;

    // Decode runs regardless of in_valid; the valid bit just rides alongside.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_alu_ctrl  <= ALU_ADD;
            r_out_valid <= 1'b0;
            r_illegal   <= 1'b0;
        end else begin
            r_alu_ctrl  <= w_op;
            r_out_valid <= in_valid;
            r_illegal   <= w_illegal;
        end
    end

    assign alu_ctrl  = r_alu_ctrl;
    assign out_valid = r_out_valid;
    assign illegal   = r_illegal;

endmodule

// File: tb/tb_alu_control.sv
// Self-checking bench for alu_control: table-driven reference model plus directed literal checks.
module tb_alu_control;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [1:0] ALUOp;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [3:0] alu_ctrl;
    logic       out_valid;
    logic       illegal;

    int checks   = 0;
    int failures = 0;

`ifdef ALU_CTRL_ILLEGAL_EN
    localparam bit ILL_EN = 1'b1;
`else
    localparam bit ILL_EN = 1'b0;
`endif

    always #5 clk = ~clk;

    alu_control dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .ALUOp     (ALUOp),
        .funct3    (funct3),
        .funct7    (funct7),
        .alu_ctrl  (alu_ctrl),
        .out_valid (out_valid),
        .illegal   (illegal)
    );

    // Reference: returns {illegal, code} straight from the decode tables.
    function automatic logic [4:0] model(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7);
        int  r_tab [8];
        int  i_tab [8];
        int  code;
        bit  ill;
        r_tab = '{2, 0, 5, 0, 8, 4, 6, 3};
        i_tab = '{0, 5, 8, 9, 4, 6, 3, 2};
        ill   = 1'b0;
        if (op == 2'd2) begin
            code = 0;
        end else if (op == 2'd3) begin
            code = 1;
        end else if (op == 2'd1) begin
            code = i_tab[f3];
            if (f3 == 3'd5 && f7[5]) code = 7;
        end else begin
            code = r_tab[f3];
            if (f3 == 3'd1 && f7[5]) code = 1;
            if (f3 == 3'd6 && f7[5]) code = 7;
            if (f3 == 3'd4 && f7[0]) code = 9;
            ill = (f3 == 3'd3)
               || !(f7 == 7'h10 || f7 == 7'h30 || f7 == 7'h01)
               || (f7[5] && f3 != 3'd1 && f3 != 3'd6);
            ill = ill && ILL_EN;
        end
        return {ill, 4'(code)};
    endfunction

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h at %0t", name, got, want, $time);
        end
    endtask

    logic [3:0] exp_code;
    logic       exp_valid;
    logic       exp_ill;
    bit         exp_known = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            exp_code  <= 4'd0;
            exp_valid <= 1'b0;
            exp_ill   <= 1'b0;
        end else begin
            {exp_ill, exp_code} <= model(ALUOp, funct3, funct7);
            exp_valid <= in_valid;
        end
        exp_known <= 1'b1;
    end

    always @(negedge clk) begin
        if (exp_known) begin
            check("model_alu_ctrl", int'(alu_ctrl), int'(exp_code));
            check("model_out_valid", int'(out_valid), int'(exp_valid));
            check("model_illegal", int'(illegal), int'(exp_ill));
        end
    end

    task automatic dir(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7,
                       input int want_code, input int want_ill);
        ALUOp    = op;
        funct3   = f3;
        funct7   = f7;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        $display("dir op=%0d f3=%0d f7=%02h -> alu_ctrl=%04b illegal=%0b", op, f3, f7, alu_ctrl, illegal);
        check("dir_alu_ctrl", int'(alu_ctrl), want_code);
        check("dir_illegal", int'(illegal), want_ill);
        check("dir_out_valid", int'(out_valid), 1);
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b1;
        ALUOp    = 2'd3;
        funct3   = 3'd3;
        funct7   = 7'h7f;
        repeat (2) @(posedge clk);
        #1;
        $display("reset -> alu_ctrl=%04b out_valid=%0b illegal=%0b", alu_ctrl, out_valid, illegal);
        check("reset_alu_ctrl", int'(alu_ctrl), 0);
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_illegal", int'(illegal), 0);
        rst = 1'b0;

        dir(2'd0, 3'd1, 7'h10, 4'b0000, 0);
        dir(2'd0, 3'd1, 7'h30, 4'b0001, 0);
        dir(2'd0, 3'd0, 7'h10, 4'b0010, 0);
        dir(2'd0, 3'd7, 7'h10, 4'b0011, 0);
        dir(2'd0, 3'd5, 7'h10, 4'b0100, 0);
        dir(2'd0, 3'd4, 7'h01, 4'b1001, 0);
        dir(2'd0, 3'd4, 7'h10, 4'b1000, 0);
        dir(2'd0, 3'd6, 7'h10, 4'b0110, 0);
        dir(2'd0, 3'd6, 7'h30, 4'b0111, 0);
        dir(2'd0, 3'd2, 7'h10, 4'b0101, 0);
        dir(2'd0, 3'd3, 7'h10, 4'b0000, int'(ILL_EN));
        dir(2'd0, 3'd0, 7'h30, 4'b0010, int'(ILL_EN));
        dir(2'd0, 3'd5, 7'h44, 4'b0100, int'(ILL_EN));
        dir(2'd1, 3'd0, 7'($urandom), 4'b0000, 0);
        dir(2'd1, 3'd6, 7'h00, 4'b0011, 0);
        dir(2'd1, 3'd5, 7'h20, 4'b0111, 0);
        dir(2'd1, 3'd5, 7'h00, 4'b0110, 0);
        dir(2'd1, 3'd3, 7'h7f, 4'b1001, 0);
        for (int i = 0; i < 4; i++) begin
            dir(2'd2, 3'($urandom), 7'($urandom), 4'b0000, 0);
            dir(2'd3, 3'($urandom), 7'($urandom), 4'b0001, 0);
        end

        // Reset mid-stream while a valid instruction is presented.
        ALUOp    = 2'd3;
        in_valid = 1'b1;
        rst      = 1'b1;
        @(posedge clk);
        #1;
        $display("mid reset -> alu_ctrl=%04b out_valid=%0b", alu_ctrl, out_valid);
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_alu_ctrl", int'(alu_ctrl), 0);
        rst = 1'b0;

        for (int i = 0; i < 500; i++) begin
            rst      = ($urandom_range(0, 31) == 0);
            in_valid = 1'($urandom);
            ALUOp    = 2'($urandom);
            funct3   = 3'($urandom);
            case ($urandom_range(0, 3))
                0:       funct7 = 7'h10;
                1:       funct7 = 7'h30;
                2:       funct7 = 7'h01;
                default: funct7 = 7'($urandom);
            endcase
            @(posedge clk);
            #1;
            $display("rnd %0d rst=%0b v=%0b op=%0d f3=%0d f7=%02h -> alu_ctrl=%04b ill=%0b",
                     i, rst, in_valid, ALUOp, funct3, funct7, alu_ctrl, illegal);
        end
        rst = 1'b0;
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
